// File: rtl/rpc_dram_responder.sv
// RPC DRAM responder: decodes command packets from the
// controller, services masked write bursts and read bursts.
module rpc_dram_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int WL         = 3,
  parameter int RL         = 4,
  parameter int T_RFC      = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rpc_cs_ni,
  input  logic        rpc_stb_i,
  input  logic [15:0] phy_db_i,
  input  logic        phy_dqs_i,
  input  logic [1:0]  phy_dm_i,
  output logic [15:0] phy_db_o,
  output logic        phy_db_oe_o,
  output logic        phy_dqs_o,
  output logic        phy_dqs_n_o,
  output logic        phy_dqs_oe_o,
  output logic [15:0] mode_reg_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD_LO,
    S_WR_WAIT,
    S_WR_DATA,
    S_RD_WAIT,
    S_RD_DATA,
    S_RD_POST,
    S_REF_BUSY,
    S_MRS
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [15:0]           r_mem [DEPTH];
  logic [15:0]           r_cmd_hi;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [15:0]           r_pay;
  logic [8:0]            r_beat;
  logic [15:0]           r_cnt;
  logic [15:0]           r_db;
  logic                  r_db_oe;
  logic                  r_dqs;
  logic                  r_dqs_oe;
  logic [15:0]           r_mode;
  logic                  r_err;

  logic                  w_start;
  logic [3:0]            w_op;
  logic                  w_op_legal;
  logic [19:0]           w_cmd_addr;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic                  w_last_wr;
  logic                  w_rd_done;
  logic                  w_burst;
  logic                  w_abort;
  logic [15:0]           w_cnt_load;
  logic [15:0]           w_db_nxt;
  logic                  w_oe_nxt;
  logic                  w_dqs_nxt;
  logic                  w_err_set;
  logic                  w_wr_en;
  logic                  w_mode_ld;
  logic                  w_unused;

  assign w_start    = !rpc_cs_ni && rpc_stb_i;
  assign w_op       = r_cmd_hi[15:12];
  assign w_op_legal = (w_op >= 4'd1) && (w_op <= 4'd4);
  assign w_cmd_addr = {r_cmd_hi[11:0], phy_db_i[15:8]};
  assign w_mem_addr = r_addr + ADDR_WIDTH'(r_beat);
  assign w_last_wr  = r_beat == {1'b0, r_len};
  assign w_rd_done  = r_beat == ({1'b0, r_len} + 9'd1);
  assign w_burst    = (r_state == S_WR_WAIT) || (r_state == S_WR_DATA) ||
                      (r_state == S_RD_WAIT) || (r_state == S_RD_DATA);
  assign w_abort    = rpc_cs_ni && w_burst;
  assign w_unused   = ^w_cmd_addr;

  assign phy_db_o     = r_db;
  assign phy_db_oe_o  = r_db_oe;
  assign phy_dqs_o    = r_dqs;
  assign phy_dqs_n_o  = r_dqs_oe & ~r_dqs;
  assign phy_dqs_oe_o = r_dqs_oe;
  assign mode_reg_o   = r_mode;
  assign err_o        = r_err;
  assign busy_o       = r_state != S_IDLE;

  // Wait-counter preload chosen so each wait state ends on time.
  always_comb begin
    w_cnt_load = '0;
    case (w_op)
      4'd1:    w_cnt_load = 16'(WL - 2);
      4'd2:    w_cnt_load = 16'(RL - 2);
      4'd3:    w_cnt_load = 16'(T_RFC - 1);
      default: w_cnt_load = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:
        if (w_start) w_state_nxt = S_CMD_LO;
      S_CMD_LO: begin
        w_state_nxt = S_IDLE;
        if (w_start) begin
          case (w_op)
            4'd1:    w_state_nxt = S_WR_WAIT;
            4'd2:    w_state_nxt = S_RD_WAIT;
            4'd3:    w_state_nxt = S_REF_BUSY;
            4'd4:    w_state_nxt = S_MRS;
            default: w_state_nxt = S_IDLE;
          endcase
        end
      end
      S_WR_WAIT:
        if (w_abort)        w_state_nxt = S_IDLE;
        else if (r_cnt == 0) w_state_nxt = S_WR_DATA;
      S_WR_DATA:
        if (w_abort) w_state_nxt = S_IDLE;
        else if (phy_dqs_i && w_last_wr) w_state_nxt = S_IDLE;
      S_RD_WAIT:
        if (w_abort)        w_state_nxt = S_IDLE;
        else if (r_cnt == 0) w_state_nxt = S_RD_DATA;
      S_RD_DATA:
        if (w_abort)        w_state_nxt = S_IDLE;
        else if (w_rd_done) w_state_nxt = S_RD_POST;
      S_RD_POST:  w_state_nxt = S_IDLE;
      S_REF_BUSY:
        if (r_cnt == 0) w_state_nxt = S_IDLE;
      S_MRS:      w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the pin registers and control strobes.
  always_comb begin
    w_db_nxt  = '0;
    w_oe_nxt  = 1'b0;
    w_dqs_nxt = 1'b0;
    w_err_set = w_abort;
    w_wr_en   = 1'b0;
    w_mode_ld = 1'b0;
    if (w_start && r_state != S_IDLE && r_state != S_CMD_LO)
      w_err_set = 1'b1;
    case (r_state)
      S_CMD_LO:
        if (!w_start || !w_op_legal) w_err_set = 1'b1;
      S_WR_DATA:
        w_wr_en = !w_abort && phy_dqs_i;
      S_RD_WAIT:
        w_oe_nxt = !w_abort && (r_cnt == 0);
      S_RD_DATA:
        if (!w_abort) begin
          w_oe_nxt = 1'b1;
          if (!w_rd_done) begin
            w_db_nxt  = r_mem[w_mem_addr];
            w_dqs_nxt = ~r_beat[0];
          end
        end
      S_MRS:
        w_mode_ld = 1'b1;
      default: ;
    endcase
  end

  // Command capture, counters and registered pin outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cmd_hi <= '0;
      r_addr   <= '0;
      r_len    <= '0;
      r_pay    <= '0;
      r_beat   <= '0;
      r_cnt    <= '0;
      r_db     <= '0;
      r_db_oe  <= 1'b0;
      r_dqs    <= 1'b0;
      r_dqs_oe <= 1'b0;
      r_mode   <= '0;
      r_err    <= 1'b0;
    end else begin
      r_db     <= w_db_nxt;
      r_db_oe  <= w_oe_nxt;
      r_dqs    <= w_dqs_nxt;
      r_dqs_oe <= w_oe_nxt;
      if (w_err_set) r_err <= 1'b1;
      if (w_mode_ld) r_mode <= r_pay;
      if (r_state == S_IDLE && w_start) r_cmd_hi <= phy_db_i;
      if (r_state == S_CMD_LO && w_start) begin
        r_addr <= w_cmd_addr[ADDR_WIDTH-1:0];
        r_len  <= phy_db_i[7:0];
        r_pay  <= w_cmd_addr[15:0];
        r_beat <= '0;
        r_cnt  <= w_cnt_load;
      end else begin
        if (r_cnt != 0 && (r_state == S_WR_WAIT ||
            r_state == S_RD_WAIT || r_state == S_REF_BUSY))
          r_cnt <= r_cnt - 16'd1;
        if (w_wr_en) r_beat <= r_beat + 9'd1;
        if (r_state == S_RD_DATA && !w_rd_done)
          r_beat <= r_beat + 9'd1;
      end
    end
  end

  // Memory array with per-byte write masking; never reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_wr_en) begin
      if (!phy_dm_i[0]) r_mem[w_mem_addr][7:0]  <= phy_db_i[7:0];
      if (!phy_dm_i[1]) r_mem[w_mem_addr][15:8] <= phy_db_i[15:8];
    end
  end

endmodule

// File: tb/tb_rpc_dram_responder.sv
// Bench for rpc_dram_responder: scenario tasks with a
// read-data scoreboard fed from a shadow memory model.
module tb_rpc_dram_responder;

  localparam int AW    = 10;
  localparam int WL    = 3;
  localparam int RL    = 4;
  localparam int T_RFC = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs_n;
  logic        stb;
  logic [15:0] db_in;
  logic        dqs_in;
  logic [1:0]  dm;
  logic [15:0] db_out;
  logic        db_oe;
  logic        dqs;
  logic        dqs_n;
  logic        dqs_oe;
  logic [15:0] mode_reg;
  logic        busy;
  logic        err;

  logic [15:0] model [1 << AW];
  logic [15:0] wdata [256];
  logic [1:0]  wdm   [256];
  logic [15:0] q_exp [$];
  int          n_checks = 0;
  int          n_errors = 0;

  rpc_dram_responder #(
    .ADDR_WIDTH(AW), .WL(WL), .RL(RL), .T_RFC(T_RFC)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .rpc_cs_ni(cs_n), .rpc_stb_i(stb),
    .phy_db_i(db_in), .phy_dqs_i(dqs_in), .phy_dm_i(dm),
    .phy_db_o(db_out), .phy_db_oe_o(db_oe),
    .phy_dqs_o(dqs), .phy_dqs_n_o(dqs_n),
    .phy_dqs_oe_o(dqs_oe), .mode_reg_o(mode_reg),
    .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; cs_n = 1'b1; stb = 1'b0;
    db_in = '0; dqs_in = 1'b0; dm = '0;
    tick();
    rst = 1'b0;
  endtask

  // Leaves the bench just after the low-half edge C.
  task automatic send_cmd(input logic [31:0] cmd);
    cs_n = 1'b0; stb = 1'b1; db_in = cmd[31:16];
    tick();
    db_in = cmd[15:0];
    tick();
    stb = 1'b0; db_in = '0;
  endtask

  task automatic wr_burst(input logic [AW-1:0] addr, input int n,
                          input int stall_at, input int abort_at);
    logic [AW-1:0] a;
    bit            stop;
    stop = 1'b0;
    send_cmd({4'h1, 20'(addr), 8'(n - 1)});
    repeat (WL - 1) tick();
    for (int k = 0; k < n; k++) begin
      if (!stop) begin
        if (k == abort_at) begin
          cs_n = 1'b1; dqs_in = 1'b0;
          tick();
          stop = 1'b1;
        end else begin
          if (k == stall_at) begin
            dqs_in = 1'b0; db_in = 16'hDEAD; dm = 2'b00;
            tick();
          end
          db_in = wdata[k]; dm = wdm[k]; dqs_in = 1'b1;
          a = addr + AW'(k);
          if (!wdm[k][0]) model[a][7:0]  = wdata[k][7:0];
          if (!wdm[k][1]) model[a][15:8] = wdata[k][15:8];
          tick();
        end
      end
    end
    dqs_in = 1'b0; dm = '0; db_in = '0; cs_n = 1'b1;
  endtask

  task automatic rd_burst(input logic [AW-1:0] addr, input int n);
    logic [15:0] e;
    logic [3:0]  ctl;
    for (int k = 0; k < n; k++) q_exp.push_back(model[addr + AW'(k)]);
    send_cmd({4'h2, 20'(addr), 8'(n - 1)});
    for (int i = 0; i < RL - 1; i++) begin
      n_checks++;
      if ({db_oe, dqs_oe} !== 2'b00) begin
        n_errors++;
        $display("FAIL rd_wait C+%0d oe got %b want 00", i, {db_oe, dqs_oe});
      end
      tick();
    end
    n_checks++;
    if ({db_oe, dqs_oe, dqs, dqs_n} !== 4'b1101) begin
      n_errors++;
      $display("FAIL preamble got %b want 1101", {db_oe, dqs_oe, dqs, dqs_n});
    end
    for (int k = 0; k < n; k++) begin
      tick();
      e = q_exp.pop_front();
      ctl = (k % 2 == 0) ? 4'b1110 : 4'b1101;
      n_checks++;
      if (db_out !== e) begin
        n_errors++;
        $display("FAIL rd_data beat %0d got %h want %h", k, db_out, e);
      end
      n_checks++;
      if ({db_oe, dqs_oe, dqs, dqs_n} !== ctl) begin
        n_errors++;
        $display("FAIL rd_ctl beat %0d got %b want %b", k,
                 {db_oe, dqs_oe, dqs, dqs_n}, ctl);
      end
    end
    tick();
    n_checks++;
    if ({db_oe, dqs_oe, dqs, dqs_n} !== 4'b1101) begin
      n_errors++;
      $display("FAIL postamble got %b want 1101", {db_oe, dqs_oe, dqs, dqs_n});
    end
    tick();
    n_checks++;
    if ({db_oe, dqs_oe, dqs, dqs_n, busy, db_out} !== 21'd0) begin
      n_errors++;
      $display("FAIL rd_end got oe=%b%b dqs=%b%b busy=%b db=%h want all 0",
               db_oe, dqs_oe, dqs, dqs_n, busy, db_out);
    end
    cs_n = 1'b1;
    n_checks++;
    if (q_exp.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard left %0d want 0", q_exp.size());
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; cs_n = 1'b1; stb = 1'b0;
    db_in = '0; dqs_in = 1'b0; dm = '0;
    tick(); tick();
    rst = 1'b0;
    n_checks++;
    if ({db_out, db_oe, dqs, dqs_n, dqs_oe} !== 20'd0) begin
      n_errors++;
      $display("FAIL reset_pins got db=%h oe=%b dqs=%b%b dqs_oe=%b want 0",
               db_out, db_oe, dqs, dqs_n, dqs_oe);
    end
    n_checks++;
    if ({mode_reg, busy, err} !== 18'd0) begin
      n_errors++;
      $display("FAIL reset_status got mode=%h busy=%b err=%b want 0",
               mode_reg, busy, err);
    end
  endtask

  task automatic test_mrs;
    send_cmd(32'h40A5_C300);
    n_checks++;
    if (mode_reg !== 16'h0000) begin
      n_errors++;
      $display("FAIL mrs_at_C got %h want 0000", mode_reg);
    end
    tick();
    cs_n = 1'b1;
    n_checks++;
    if ({mode_reg, err, busy} !== {16'hA5C3, 2'b00}) begin
      n_errors++;
      $display("FAIL mrs_at_C1 got mode=%h err=%b busy=%b want A5C3 0 0",
               mode_reg, err, busy);
    end
  endtask

  task automatic test_wr_rd;
    for (int k = 0; k < 4; k++) begin
      wdata[k] = 16'h1111 * 16'(k + 1);
      wdm[k]   = 2'b00;
    end
    wr_burst(10'h010, 4, -1, -1);
    n_checks++;
    if ({busy, err} !== 2'b00) begin
      n_errors++;
      $display("FAIL wr_done got busy=%b err=%b want 0 0", busy, err);
    end
    rd_burst(10'h010, 4);
  endtask

  task automatic test_wrap_mask;
    wdata[0] = 16'hBEEF; wdm[0] = 2'b00;
    wr_burst(10'h3FF, 1, -1, -1);
    wdata[0] = 16'hA001; wdm[0] = 2'b00;
    wdata[1] = 16'hAA55; wdm[1] = 2'b01;
    wdata[2] = 16'hA003; wdm[2] = 2'b00;
    wdata[3] = 16'hA004; wdm[3] = 2'b00;
    wr_burst(10'h3FE, 4, 2, -1);
    rd_burst(10'h3FE, 4);
    n_checks++;
    if (err !== 1'b0) begin
      n_errors++;
      $display("FAIL wrap_err got %b want 0", err);
    end
  endtask

  task automatic test_ref;
    int nbusy;
    nbusy = 0;
    send_cmd(32'h3000_0000);
    cs_n = 1'b1;
    n_checks++;
    if (err !== 1'b0) begin
      n_errors++;
      $display("FAIL ref_err_before got %b want 0", err);
    end
    for (int i = 0; i < 40; i++) begin
      if (busy) nbusy++;
      if (i == 5) begin
        cs_n = 1'b0; stb = 1'b1; db_in = 16'h2000;
      end else begin
        cs_n = 1'b1; stb = 1'b0; db_in = '0;
      end
      tick();
    end
    n_checks++;
    if (nbusy != T_RFC) begin
      n_errors++;
      $display("FAIL ref_busy_cycles got %0d want %0d", nbusy, T_RFC);
    end
    n_checks++;
    if ({err, busy, db_oe} !== 3'b100) begin
      n_errors++;
      $display("FAIL ref_stray_start got err=%b busy=%b oe=%b want 1 0 0",
               err, busy, db_oe);
    end
    do_reset();
  endtask

  task automatic test_abort;
    for (int k = 0; k < 8; k++) begin
      wdata[k] = 16'h5000 + 16'(k);
      wdm[k]   = 2'b00;
    end
    wr_burst(10'h100, 8, -1, -1);
    for (int k = 0; k < 8; k++) wdata[k] = 16'h6000 + 16'(k);
    wr_burst(10'h100, 8, -1, 3);
    n_checks++;
    if ({err, busy} !== 2'b10) begin
      n_errors++;
      $display("FAIL abort got err=%b busy=%b want 1 0", err, busy);
    end
    do_reset();
    rd_burst(10'h100, 8);
  endtask

  task automatic test_illegal;
    send_cmd(32'h5000_0000);
    cs_n = 1'b1;
    n_checks++;
    if ({err, busy} !== 2'b10) begin
      n_errors++;
      $display("FAIL bad_op got err=%b busy=%b want 1 0", err, busy);
    end
    do_reset();
    cs_n = 1'b0; stb = 1'b1; db_in = 16'h1000;
    tick();
    stb = 1'b0; db_in = '0;
    tick();
    cs_n = 1'b1;
    n_checks++;
    if ({err, busy} !== 2'b10) begin
      n_errors++;
      $display("FAIL lost_cmd_lo got err=%b busy=%b want 1 0", err, busy);
    end
    do_reset();
  endtask

  task automatic test_rst_mid_rd;
    send_cmd({4'h2, 20'h00010, 8'd3});
    repeat (RL) tick();
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (db_out !== model[10'h010 + AW'(k)]) begin
        n_errors++;
        $display("FAIL rst_rd beat %0d got %h want %h", k, db_out,
                 model[10'h010 + AW'(k)]);
      end
      if (k < 2) tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; cs_n = 1'b1;
    n_checks++;
    if ({db_oe, dqs_oe, dqs_n, busy, err} !== 5'd0) begin
      n_errors++;
      $display("FAIL rst_mid_rd got oe=%b%b dqs_n=%b busy=%b err=%b want 0",
               db_oe, dqs_oe, dqs_n, busy, err);
    end
    rd_burst(10'h010, 4);
  endtask

  initial begin
    test_reset();
    test_mrs();
    test_wr_rd();
    test_wrap_mask();
    test_ref();
    test_abort();
    test_illegal();
    test_rst_mid_rd();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
